// File: rtl/alu_mul_sequencer.sv
// Iterative 32x32 shift-and-add multiply sequencer. Borrows the shared EX-stage
// ALU (ADD for accumulate, SLL for multiplicand shift) and produces the low
// 32 bits of op_a*op_b, which is correct for signed and unsigned operands.
module alu_mul_sequencer #(
  parameter int ITER       = 32,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        start_valid,
  output logic        start_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [31:0] alu_src1,
  output logic [31:0] alu_src2,
  output logic [1:0]  alu_func,
  output logic [4:0]  alu_shift,
  input  logic [31:0] alu_result,
  output logic        result_valid,
  input  logic        result_ready,
  output logic [31:0] result,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STEP,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam logic [1:0] F_SLL = 2'b00;
  localparam logic [1:0] F_ADD = 2'b01;
  localparam logic [5:0] LAST  = 6'(ITER - 1);

  state_t      state;
  logic [31:0] p;    // accumulator
  logic [31:0] m;    // multiplicand, shifted left once per iteration
  logic [31:0] q;    // multiplier, shifted right once per iteration
  logic [5:0]  cnt;  // completed iterations
  logic        accept;

  // NOTE: start_ready is combinational on flush so a start in the same cycle
  // as a flush is never handshaken; everything else below is a plain register.
  assign start_ready = (state == S_IDLE) && !flush;
  assign busy        = (state != S_IDLE);
  assign accept      = start_valid && start_ready;

  // Sequencer FSM. ALU controls are registered and set on entry to each state,
  // so the ALU sees the right operands for the whole of STEP and SHIFT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register here samples the pre-edge values of its neighbours.
      state        <= S_IDLE;
      p            <= '0;
      m            <= '0;
      q            <= '0;
      cnt          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      alu_src1     <= '0;
      alu_src2     <= '0;
      alu_func     <= F_SLL;
      alu_shift    <= '0;
    end else if (flush) begin
      // Abort wins over every transition; partial P/M/Q are simply abandoned.
      state        <= S_IDLE;
      result_valid <= 1'b0;
      alu_src1     <= '0;
      alu_src2     <= '0;
      alu_func     <= F_SLL;
      alu_shift    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            p   <= '0;
            m   <= op_a;
            q   <= op_b;
            cnt <= '0;
            if (EARLY_EXIT && (op_b == 32'd0)) begin
              state        <= S_DONE;
              result       <= '0;
              result_valid <= 1'b1;
            end else begin
              // First STEP adds M=op_a onto P=0.
              state     <= S_STEP;
              alu_func  <= F_ADD;
              alu_src1  <= '0;
              alu_src2  <= op_a;
              alu_shift <= '0;
            end
          end
        end

        S_STEP: begin
          if (q[0]) p <= alu_result;
          state     <= S_SHIFT;
          alu_func  <= F_SLL;
          alu_src1  <= m;
          alu_src2  <= '0;
          alu_shift <= 5'd1;
        end

        S_SHIFT: begin
          m   <= alu_result;
          q   <= q >> 1;
          cnt <= cnt + 6'd1;
          if ((cnt == LAST) || (EARLY_EXIT && (q[31:1] == 31'd0))) begin
            // P already holds the final sum: it was updated in the last STEP.
            state        <= S_DONE;
            result       <= p;
            result_valid <= 1'b1;
            alu_func     <= F_SLL;
            alu_src1     <= '0;
            alu_src2     <= '0;
            alu_shift    <= '0;
          end else begin
            // Next STEP adds the freshly shifted multiplicand.
            state     <= S_STEP;
            alu_func  <= F_ADD;
            alu_src1  <= p;
            alu_src2  <= alu_result;
            alu_shift <= '0;
          end
        end

        S_DONE: begin
          if (result_ready) begin
            state        <= S_IDLE;
            result_valid <= 1'b0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Self-checking bench for alu_mul_sequencer: models the shared ALU, runs the
// directed scenarios and a randomized batch against an arithmetic reference.
module tb_alu_mul_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        start_valid = 1'b0;
  logic        start_ready;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [31:0] alu_src1, alu_src2, alu_result;
  logic [1:0]  alu_func;
  logic [4:0]  alu_shift;
  logic        result_valid;
  logic        result_ready = 1'b0;
  logic [31:0] result;
  logic        busy;

  int total = 0;
  int bad = 0;
  int sub_or_seen = 0;
  logic [1:0] fseq[$];

  alu_mul_sequencer #(.ITER(32), .EARLY_EXIT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .start_valid(start_valid), .start_ready(start_ready),
    .op_a(op_a), .op_b(op_b),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_func(alu_func),
    .alu_shift(alu_shift), .alu_result(alu_result),
    .result_valid(result_valid), .result_ready(result_ready),
    .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  // Shared ALU model: combinational, same-cycle result.
  always_comb begin
    alu_result = '0;
    case (alu_func)
      2'b00: alu_result = alu_src1 << alu_shift;
      2'b01: alu_result = alu_src1 + alu_src2;
      2'b10: alu_result = alu_src1 - alu_src2;
      default: alu_result = alu_src1 | alu_src2;
    endcase
  end

  // The sequencer must never issue SUB or OR.
  always @(posedge clk) if (alu_func[1]) sub_or_seen++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Iterations needed with early exit: index of the top set bit plus one.
  function automatic int ref_n(input logic [31:0] b);
    int n = 0;
    for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
    return n;
  endfunction

  function automatic logic [31:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] pr;
    pr = a * b;
    return pr;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    int g = 0;
    while (!start_ready && g < 200) begin step(); g++; end
    if (!start_ready) check("start_timeout", 32'd0, 32'd1);
    op_a = a;
    op_b = b;
    start_valid = 1'b1;
    step();
    start_valid = 1'b0;
  endtask

  // Counts edges from the accept edge until result_valid, logging ALU funcs.
  task automatic wait_done(output int cycles);
    cycles = 0;
    fseq.delete();
    while (!result_valid && cycles < 300) begin
      fseq.push_back(alu_func);
      step();
      cycles++;
    end
    if (!result_valid) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic take();
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b);
    int c;
    int adds;
    start_op(a, b);
    wait_done(c);
    check({tag, "_result"}, result, ref_prod(a, b));
    check({tag, "_latency"}, 32'(c), 32'(2 * ref_n(b)));
    adds = 0;
    foreach (fseq[i]) if (fseq[i] == 2'b01) adds++;
    check({tag, "_adds"}, 32'(adds), 32'(ref_n(b)));
    take();
    check({tag, "_valid_drop"}, {31'd0, result_valid}, 32'd0);
  endtask

  initial begin
    int c;
    int ones;
    logic [31:0] ra, rb, held;
    logic [1:0] exp_seq[6];
    exp_seq = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00};

    // Reset state.
    #2;
    check("rst_ready", {31'd0, start_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, result_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_alu", {alu_src1 | alu_src2, 27'd0, alu_func, alu_shift} == 64'd0 ? 32'd0 : 32'd1, 32'd0);
    #10 rst_n = 1'b1;
    step();

    // T1: 3*5, func sequence and DONE-state ALU drive.
    start_op(32'd3, 32'd5);
    wait_done(c);
    check("t1_result", result, 32'd15);
    check("t1_latency", 32'(c), 32'd6);
    check("t1_seq_len", 32'(fseq.size()), 32'd6);
    for (int i = 0; i < 6 && i < fseq.size(); i++)
      check($sformatf("t1_func%0d", i), {30'd0, fseq[i]}, {30'd0, exp_seq[i]});
    check("t1_done_func", {30'd0, alu_func}, 32'd0);
    check("t1_done_src1", alu_src1, 32'd0);
    check("t1_done_shift", {27'd0, alu_shift}, 32'd0);
    take();

    // T2: multiplier zero finishes at the accept edge without any ADD.
    run_op("t2", 32'h1234, 32'd0);

    // T3: full-length and signed operands.
    run_op("t3_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("t3_neg", 32'hFFFF_FFFE, 32'd3);

    // T4: backpressure holds the result and blocks new starts.
    start_op(32'd7, 32'd6);
    wait_done(c);
    check("t4_result", result, 32'd42);
    held = result;
    ones = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (result !== held || start_ready !== 1'b0 || result_valid !== 1'b1) ones++;
    end
    check("t4_hold", 32'(ones), 32'd0);
    check("t4_held_value", result, 32'd42);
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    check("t4_idle_busy", {31'd0, busy}, 32'd0);
    check("t4_idle_ready", {31'd0, start_ready}, 32'd1);
    start_op(32'd1, 32'd1);
    check("t4_reaccept", {31'd0, busy}, 32'd1);
    wait_done(c);
    check("t4_second", result, 32'd1);
    take();

    // T5: flush mid-operation, then a start during flush in IDLE.
    start_op(32'h10000, 32'h10000);
    for (int i = 0; i < 4; i++) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("t5_flush_busy", {31'd0, busy}, 32'd0);
    ones = 0;
    for (int i = 0; i < 70; i++) begin
      if (result_valid) ones++;
      step();
    end
    check("t5_no_valid", 32'(ones), 32'd0);
    op_a = 32'd5;
    op_b = 32'd5;
    start_valid = 1'b1;
    flush = 1'b1;
    #1;
    check("t5_flush_ready", {31'd0, start_ready}, 32'd0);
    step();
    start_valid = 1'b0;
    flush = 1'b0;
    check("t5_flush_noaccept", {31'd0, busy}, 32'd0);
    run_op("t5_after", 32'd2, 32'd2);

    // T6: asynchronous reset between edges.
    start_op(32'h55, 32'hFFFF);
    for (int i = 0; i < 3; i++) step();
    #2 rst_n = 1'b0;
    #1;
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_ready", {31'd0, start_ready}, 32'd1);
    check("t6_valid", {31'd0, result_valid}, 32'd0);
    check("t6_result", result, 32'd0);
    check("t6_alu_src", alu_src1 | alu_src2, 32'd0);
    check("t6_alu_ctl", {25'd0, alu_func, alu_shift}, 32'd0);
    step();
    #2 rst_n = 1'b1;
    step();
    run_op("t6_after", 32'd9, 32'd9);

    // Randomized operands, with multiplier widths spread across 0..32 bits.
    for (int k = 0; k < 40; k++) begin
      ra = $urandom();
      rb = $urandom();
      rb = (k % 8 == 0) ? 32'd0 : rb >> $urandom_range(0, 31);
      run_op($sformatf("rnd%0d", k), ra, rb);
    end

    check("no_sub_or", 32'(sub_or_seen), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
